// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  localparam int BLK_DEFAULT = 4;

  function automatic int seg_w(input int w, input int stages);
    return w / stages;
  endfunction

endpackage

// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for cla_pipe_addsub.
// sat_i exists only when CLA_SAT_EN is defined.
interface cla_pipe_addsub_if #(parameter int W = 16);
  import cla_pkg::*;

  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] A_i;
  logic [W-1:0] B_i;
  logic         P_i;
  op_t          op_i;
`ifdef CLA_SAT_EN
  logic         sat_i;
`endif
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] S_o;
  logic         C_o;
  logic         V_o;
  logic         Z_o;
  logic [W:0]   full_add;

`ifdef CLA_SAT_EN
  modport slave  (input  in_valid_i, A_i, B_i, P_i, op_i, sat_i, out_ready_i,
                  output in_ready_o, out_valid_o, S_o, C_o, V_o, Z_o, full_add);
  modport master (output in_valid_i, A_i, B_i, P_i, op_i, sat_i, out_ready_i,
                  input  in_ready_o, out_valid_o, S_o, C_o, V_o, Z_o, full_add);
`else
  modport slave  (input  in_valid_i, A_i, B_i, P_i, op_i, out_ready_i,
                  output in_ready_o, out_valid_o, S_o, C_o, V_o, Z_o, full_add);
  modport master (output in_valid_i, A_i, B_i, P_i, op_i, out_ready_i,
                  input  in_ready_o, out_valid_o, S_o, C_o, V_o, Z_o, full_add);
`endif

endinterface

// File: rtl/cla_seg.sv
// Combinational SW-bit carry-lookahead segment built from BLK-wide groups.
// Also reports the carry into its MSB so the top can derive signed overflow.
module cla_seg #(
  parameter int SW  = 8,
  parameter int BLK = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          c_msb_in
);
  localparam int NG = SW / BLK;

  logic [SW-1:0] p_s;
  logic [SW-1:0] g_s;
  logic [NG-1:0] gp_s;
  logic [NG-1:0] gg_s;
  logic [NG:0]   gc_s;
  logic [SW:0]   c_s;

  assign p_s = a ^ b;
  assign g_s = a & b;

  // group P/G, lookahead group carries from cin, then bit carries inside each group
  always_comb begin
    logic acc;
    gp_s = '0;
    gg_s = '0;
    gc_s = '0;
    c_s  = '0;
    acc  = 1'b0;
    for (int j = 0; j < NG; j++) begin
      gp_s[j] = &p_s[j*BLK +: BLK];
      acc = 1'b0;
      for (int i = 0; i < BLK; i++) acc = g_s[j*BLK+i] | (p_s[j*BLK+i] & acc);
      gg_s[j] = acc;
    end
    gc_s[0] = cin;
    for (int j = 0; j < NG; j++) begin
      acc = cin;
      for (int i = 0; i <= j; i++) acc = gg_s[i] | (gp_s[i] & acc);
      gc_s[j+1] = acc;
    end
    for (int j = 0; j < NG; j++) begin
      acc = gc_s[j];
      for (int i = 0; i < BLK; i++) begin
        c_s[j*BLK+i] = acc;
        acc = g_s[j*BLK+i] | (p_s[j*BLK+i] & acc);
      end
    end
    c_s[SW] = gc_s[NG];
  end

  assign sum      = p_s ^ c_s[SW-1:0];
  assign cout     = c_s[SW];
  assign c_msb_in = c_s[SW-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined CLA adder/subtractor: one W/STAGES segment resolves per stage, carry registered between.
// Optional saturation on signed overflow is built when CLA_SAT_EN is defined.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int W      = 16,
  parameter int BLK    = BLK_DEFAULT,
  parameter int STAGES = 2
) (
  input logic              CLK_i,
  input logic              rst_n_i,
  cla_pipe_addsub_if.slave bus
);
  localparam int SW  = seg_w(W, STAGES);
  localparam int LST = STAGES - 1;

  if ((STAGES < 1) || ((W % (STAGES * BLK)) != 0)) begin : g_param_chk
    $error("cla_pipe_addsub: W must be a multiple of STAGES*BLK");
  end

  logic         en_s;
  logic [W-1:0] b_cond_s;
  logic         cin_cond_s;

  logic         vld_r [STAGES];
  logic [W-1:0] a_r   [STAGES];
  logic [W-1:0] b_r   [STAGES];
  logic [W-1:0] s_r   [STAGES];
  logic         c_r   [STAGES];
  logic         v_r;
  logic         z_r;

  logic [W-1:0]  a_in_s     [STAGES];
  logic [W-1:0]  b_in_s     [STAGES];
  logic [W-1:0]  s_in_s     [STAGES];
  logic [W-1:0]  s_nxt_s    [STAGES];
  logic          cin_in_s   [STAGES];
  logic          vld_in_s   [STAGES];
  logic [SW-1:0] seg_sum_s  [STAGES];
  logic          seg_cout_s [STAGES];
  logic          seg_cmsb_s [STAGES];
  logic [W-1:0]  s_fin_s;
  logic          v_fin_s;
`ifdef CLA_SAT_EN
  logic          sat_r      [STAGES];
  logic          sat_in_s   [STAGES];
`endif

  assign en_s           = !vld_r[LST] | bus.out_ready_i;
  assign bus.in_ready_o = en_s;

  // subtraction is A + ~B + 1; P_i is ignored for OP_SUB
  always_comb begin
    if (bus.op_i == OP_SUB) begin
      b_cond_s   = ~bus.B_i;
      cin_cond_s = 1'b1;
    end else begin
      b_cond_s   = bus.B_i;
      cin_cond_s = bus.P_i;
    end
  end

  // stage k takes its operands from stage k-1, stage 0 from the conditioned inputs
  always_comb begin
    a_in_s[0]   = bus.A_i;
    b_in_s[0]   = b_cond_s;
    s_in_s[0]   = '0;
    cin_in_s[0] = cin_cond_s;
    vld_in_s[0] = bus.in_valid_i;
`ifdef CLA_SAT_EN
    sat_in_s[0] = bus.sat_i;
`endif
    for (int k = 1; k < STAGES; k++) begin
      a_in_s[k]   = a_r[k-1];
      b_in_s[k]   = b_r[k-1];
      s_in_s[k]   = s_r[k-1];
      cin_in_s[k] = c_r[k-1];
      vld_in_s[k] = vld_r[k-1];
`ifdef CLA_SAT_EN
      sat_in_s[k] = sat_r[k-1];
`endif
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    cla_seg #(.SW(SW), .BLK(BLK)) u_seg (
      .a        (a_in_s[k][k*SW +: SW]),
      .b        (b_in_s[k][k*SW +: SW]),
      .cin      (cin_in_s[k]),
      .sum      (seg_sum_s[k]),
      .cout     (seg_cout_s[k]),
      .c_msb_in (seg_cmsb_s[k])
    );
  end

  // splice each resolved segment in; flags and clamp come from the last segment
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_nxt_s[k] = s_in_s[k];
      s_nxt_s[k][k*SW +: SW] = seg_sum_s[k];
    end
    v_fin_s = seg_cmsb_s[LST] ^ seg_cout_s[LST];
    s_fin_s = s_nxt_s[LST];
`ifdef CLA_SAT_EN
    if (sat_in_s[LST] && v_fin_s) begin
      s_fin_s = a_in_s[LST][W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      s_fin_s = s_nxt_s[LST];
    end
`endif
  end

  // pipeline registers; the whole pipe advances together and bubbles are kept
  always_ff @(posedge CLK_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_r[k] <= 1'b0;
        a_r[k]   <= '0;
        b_r[k]   <= '0;
        s_r[k]   <= '0;
        c_r[k]   <= 1'b0;
`ifdef CLA_SAT_EN
        sat_r[k] <= 1'b0;
`endif
      end
      v_r <= 1'b0;
      z_r <= 1'b0;
    end else if (en_s) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_r[k] <= vld_in_s[k];
        a_r[k]   <= a_in_s[k];
        b_r[k]   <= b_in_s[k];
        s_r[k]   <= (k == LST) ? s_fin_s : s_nxt_s[k];
        c_r[k]   <= seg_cout_s[k];
`ifdef CLA_SAT_EN
        sat_r[k] <= sat_in_s[k];
`endif
      end
      v_r <= v_fin_s;
      z_r <= ~|s_fin_s;
    end
  end

  assign bus.out_valid_o = vld_r[LST];
  assign bus.S_o         = s_r[LST];
  assign bus.C_o         = c_r[LST];
  assign bus.V_o         = v_r;
  assign bus.Z_o         = z_r;
  assign bus.full_add    = {c_r[LST], s_r[LST]};

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed and random self-checking bench for cla_pipe_addsub (W=16, STAGES=2).
// Saturation vectors are added when CLA_SAT_EN is defined.
module tb_cla_pipe_addsub;
  import cla_pkg::*;

  localparam int W   = 16;
  localparam int STG = 2;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         p;
    logic         op;
    logic         sat;
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         z;
    int           adv;
  } beat_t;

  logic CLK_i   = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 CLK_i = ~CLK_i;

  cla_pipe_addsub_if #(.W(W)) bus();

  cla_pipe_addsub #(.W(W), .BLK(4), .STAGES(STG)) dut (
    .CLK_i   (CLK_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  int     n_chk = 0;
  int     n_err = 0;
  int     adv   = 0;
  int     n_acc = 0;
  int     n_pop = 0;
  bit     prev_en = 1'b0;
  bit     rnd_done;
  beat_t  exp_q[$];
  beat_t  drv_b;
  beat_t  mon_b;
  logic [W-1:0] h_s;
  logic   h_c, h_v, h_z;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic p,
                               input logic op, input logic sat, input logic [W-1:0] s,
                               input logic c, input logic v, input logic z);
    beat_t r;
    r.a = a; r.b = b; r.p = p; r.op = op; r.sat = sat;
    r.s = s; r.c = c; r.v = v; r.z = z; r.adv = 0;
    return r;
  endfunction

  function automatic beat_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic p,
                                  input logic op, input logic sat);
    beat_t r;
    logic [W-1:0] bb;
    logic [W:0]   f;
    bb = op ? ~b : b;
    f  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (op ? 1'b1 : p)};
    r  = mk(a, b, p, op, sat, f[W-1:0], f[W], (a[W-1] == bb[W-1]) && (f[W-1] != a[W-1]), 1'b0);
    if (sat && r.v) r.s = a[W-1] ? 16'h8000 : 16'h7FFF;
    r.z = (r.s == 16'h0000);
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge CLK_i);
    #1;
  endtask

  // present one beat and hold it until accepted; entered and left at posedge+1
  task automatic send(input beat_t bt);
    int k;
    drv_b    = bt;
    bus.A_i  = bt.a;
    bus.B_i  = bt.b;
    bus.P_i  = bt.p;
    bus.op_i = bt.op ? OP_SUB : OP_ADD;
`ifdef CLA_SAT_EN
    bus.sat_i = bt.sat;
`endif
    bus.in_valid_i = 1'b1;
    k = 0;
    @(negedge CLK_i);
    while (!bus.in_ready_o && k < 100) begin
      k++;
      @(negedge CLK_i);
    end
    if (k >= 100) check("accept_timeout", 32'd0, 32'd1);
    @(posedge CLK_i);
    #1;
    bus.in_valid_i = 1'b0;
  endtask

  // scoreboard: record accepts, compare each new output beat, check held outputs under stall
  always @(negedge CLK_i) begin
    if (!rst_n_i) begin
      n_acc   = n_acc - exp_q.size();
      exp_q.delete();
      prev_en = 1'b0;
    end else begin
      if (bus.out_valid_o) begin
        if (prev_en) begin
          if (exp_q.size() == 0) begin
            check("spurious_beat", 32'd1, 32'd0);
          end else begin
            mon_b = exp_q.pop_front();
            n_pop++;
            check("latency", adv, mon_b.adv + STG);
            check("S", bus.S_o, mon_b.s);
            check("C", bus.C_o, mon_b.c);
            check("V", bus.V_o, mon_b.v);
            check("Z", bus.Z_o, mon_b.z);
            check("full_add", bus.full_add, {mon_b.c, mon_b.s});
          end
        end else begin
          check("stall_S", bus.S_o, h_s);
          check("stall_CVZ", {bus.C_o, bus.V_o, bus.Z_o}, {h_c, h_v, h_z});
        end
        h_s = bus.S_o; h_c = bus.C_o; h_v = bus.V_o; h_z = bus.Z_o;
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        drv_b.adv = adv;
        exp_q.push_back(drv_b);
        n_acc++;
      end
      if (bus.in_ready_o) adv++;
      prev_en = bus.in_ready_o;
    end
  end

  initial begin
    int    base;
    int    k;
    beat_t dir_q[$];
    bus.in_valid_i  = 1'b0;
    bus.A_i         = '0;
    bus.B_i         = '0;
    bus.P_i         = 1'b0;
    bus.op_i        = OP_ADD;
`ifdef CLA_SAT_EN
    bus.sat_i       = 1'b0;
`endif
    bus.out_ready_i = 1'b1;

    // reset values
    #1;
    check("rst_valid", bus.out_valid_o, 1'b0);
    check("rst_S", bus.S_o, 16'h0000);
    check("rst_Z", bus.Z_o, 1'b0);
    check("rst_CV", {bus.C_o, bus.V_o}, 2'b00);
    check("rst_ready", bus.in_ready_o, 1'b1);
    idle(3);
    rst_n_i = 1'b1;
    idle(2);

    // reset with two beats in flight
    base = n_pop;
    send(mk(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0));
    send(mk(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0));
    rst_n_i = 1'b0;
    #1;
    check("midrst_valid", bus.out_valid_o, 1'b0);
    check("midrst_S", bus.S_o, 16'h0000);
    check("midrst_Z", bus.Z_o, 1'b0);
    idle(2);
    rst_n_i = 1'b1;
    idle(6);
    check("midrst_no_emit", n_pop, base);
    check("midrst_flush", exp_q.size(), 0);

    // back-to-back directed vectors with hand-computed results
    dir_q.push_back(mk(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0));
    dir_q.push_back(mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1));
    dir_q.push_back(mk(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0));
    dir_q.push_back(mk(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0));
    dir_q.push_back(mk(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0));
    dir_q.push_back(mk(16'h0010, 16'h0010, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1));
    dir_q.push_back(mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0));
    dir_q.push_back(mk(16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0));
`ifdef CLA_SAT_EN
    dir_q.push_back(mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0));
    dir_q.push_back(mk(16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0));
    dir_q.push_back(mk(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0));
`endif
    base = n_pop;
    foreach (dir_q[i]) send(dir_q[i]);
    idle(4);
    check("dir_count", n_pop - base, dir_q.size());
    check("dir_drain", exp_q.size(), 0);

    // backpressure: output stalled 5 clk while beats queue up behind it
    base = n_pop;
    bus.out_ready_i = 1'b0;
    fork
      begin
        send(mk(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0));
        send(mk(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0));
        send(mk(16'h1000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0FFF, 1'b1, 1'b0, 1'b0));
      end
      begin
        k = 0;
        while (!bus.out_valid_o && k < 20) begin
          k++;
          @(negedge CLK_i);
        end
        if (k >= 20) check("bp_valid_timeout", 32'd0, 32'd1);
        repeat (5) begin
          @(negedge CLK_i);
          check("bp_in_ready", bus.in_ready_o, 1'b0);
        end
        @(posedge CLK_i);
        #1;
        bus.out_ready_i = 1'b1;
      end
    join
    idle(5);
    check("bp_count", n_pop - base, 3);
    check("bp_drain", exp_q.size(), 0);

    // random beats with random idle gaps and random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          logic [W-1:0] ra, rb;
          logic rp, ro, rs;
          ra = W'($urandom);
          rb = W'($urandom);
          rp = 1'($urandom);
          ro = 1'($urandom);
`ifdef CLA_SAT_EN
          rs = 1'($urandom);
`else
          rs = 1'b0;
`endif
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          send(model(ra, rb, rp, ro, rs));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge CLK_i);
          #1;
          bus.out_ready_i = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready_i = 1'b1;
      end
    join
    k = 0;
    while ((exp_q.size() != 0) && k < 200) begin
      k++;
      idle(1);
    end
    idle(2);
    check("rnd_drain", exp_q.size(), 0);
    check("total_count", n_pop, n_acc);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
